axi_aw_w_joiner: RTL and testbench

Parametrised AW/W channel joiner for the cache's AXI write path. It accepts write-address and write-data channels independently, buffers addresses in an AW_DEPTH-entry FIFO, and issues them downstream in order. Each W burst is released downstream only after its own AW has completed its downstream handshake. Up to MAX_OUTSTANDING issued bursts may await data, and per-burst beats are tracked against awlen.

---
 rtl/axi_aw_w_joiner.sv | 194 +++++++++++++++++++
 tb/tb_axi_aw_w_joiner.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_w_joiner.sv
// axi_aw_w_joiner: buffers write addresses in a small FIFO, issues them downstream
// in order, and lets each W burst through only once its AW has been accepted
// downstream. A length FIFO tracks issued bursts that are still waiting for data.
// Optional feature macro: AXI_JOINER_WLAST_CHECK_EN. When it is defined, wlast is
// generated from awlen and upstream wlast mismatches raise a sticky err_wlast.
module axi_aw_w_joiner #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter int AW_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            in_awaddr,
  input  logic [ID_WIDTH-1:0]              in_awid,
  input  logic [1:0]                       in_awburst,
  input  logic [2:0]                       in_awsize,
  input  logic [7:0]                       in_awlen,
  input  logic                             in_awvalid,
  output logic                             in_awready,
  input  logic [DATA_WIDTH-1:0]            in_wdata,
  input  logic [DATA_WIDTH/8-1:0]          in_wstrb,
  input  logic                             in_wlast,
  input  logic                             in_wvalid,
  output logic                             in_wready,
  output logic [ADDR_WIDTH-1:0]            out_awaddr,
  output logic [ID_WIDTH-1:0]              out_awid,
  output logic [1:0]                       out_awburst,
  output logic [2:0]                       out_awsize,
  output logic [7:0]                       out_awlen,
  output logic                             out_awvalid,
  input  logic                             out_awready,
  output logic [DATA_WIDTH-1:0]            out_wdata,
  output logic [DATA_WIDTH/8-1:0]          out_wstrb,
  output logic                             out_wlast,
  output logic                             out_wvalid,
  input  logic                             out_wready,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_wlast
);

  localparam int AW_W   = ADDR_WIDTH + ID_WIDTH + 2 + 3 + 8;
  localparam int AW_PW  = $clog2(AW_DEPTH);
  localparam int AW_CW  = AW_PW + 1;
  localparam int LEN_CW = $clog2(MAX_OUTSTANDING) + 1;

  // AW FIFO storage and bookkeeping
  logic [AW_W-1:0]   aw_mem [AW_DEPTH];
  logic [AW_PW-1:0]  aw_wr_ptr_reg;
  logic [AW_PW-1:0]  aw_rd_ptr_reg;
  logic [AW_CW-1:0]  aw_count_reg;
  logic [AW_W-1:0]   aw_head;

  // Issued-burst tracking: only the occupancy is needed unless wlast is generated
  logic [LEN_CW-1:0] len_count_reg;

  logic aw_full;
  logic aw_empty;
  logic len_full;
  logic w_open;
  logic aw_push;
  logic aw_pop;
  logic len_push;
  logic len_pop;
  logic w_hs;
  logic w_term;

  // Flags come straight from registered counts, so the handshake outputs carry
  // no combinational path from the same-cycle valid inputs.
  assign aw_full  = (aw_count_reg == AW_CW'(AW_DEPTH));
  assign aw_empty = (aw_count_reg == '0);
  assign len_full = (len_count_reg == LEN_CW'(MAX_OUTSTANDING));
  assign w_open   = (len_count_reg != '0);

  assign in_awready  = !aw_full;
  assign out_awvalid = !aw_empty && !len_full;
  assign aw_push     = in_awvalid && in_awready;
  assign aw_pop      = out_awvalid && out_awready;
  assign len_push    = aw_pop;
  assign len_pop     = w_term;

  // W is never buffered: both directions are simply gated by w_open
  assign out_wvalid = in_wvalid && w_open;
  assign in_wready  = out_wready && w_open;
  assign out_wdata  = in_wdata;
  assign out_wstrb  = in_wstrb;
  assign w_hs       = in_wvalid && out_wready && w_open;

  // The FIFO head is read combinationally so an AW accepted at one edge is
  // presented downstream in the very next cycle.
  assign aw_head = aw_mem[aw_rd_ptr_reg];
  assign {out_awaddr, out_awid, out_awburst, out_awsize, out_awlen} = aw_head;

  assign outstanding = len_count_reg;

  // AW payload storage; contents need no reset because occupancy guards every read
  always_ff @(posedge clk) begin
    if (aw_push) begin
      aw_mem[aw_wr_ptr_reg] <= {in_awaddr, in_awid, in_awburst, in_awsize, in_awlen};
    end
  end

  // AW FIFO pointers and occupancy (depth is a power of two, pointers wrap naturally)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wr_ptr_reg <= '0;
      aw_rd_ptr_reg <= '0;
      aw_count_reg  <= '0;
    end else begin
      if (aw_push) aw_wr_ptr_reg <= aw_wr_ptr_reg + AW_PW'(1);
      if (aw_pop)  aw_rd_ptr_reg <= aw_rd_ptr_reg + AW_PW'(1);
      if (aw_push && !aw_pop)      aw_count_reg <= aw_count_reg + AW_CW'(1);
      else if (!aw_push && aw_pop) aw_count_reg <= aw_count_reg - AW_CW'(1);
    end
  end

  // Issued-burst occupancy: simultaneous issue and burst completion cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_count_reg <= '0;
    end else if (len_push && !len_pop) begin
      len_count_reg <= len_count_reg + LEN_CW'(1);
    end else if (!len_push && len_pop) begin
      len_count_reg <= len_count_reg - LEN_CW'(1);
    end
  end

`ifdef AXI_JOINER_WLAST_CHECK_EN
  localparam int LEN_PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [7:0]        len_mem [MAX_OUTSTANDING];
  logic [LEN_PW-1:0] len_wr_ptr_reg;
  logic [LEN_PW-1:0] len_rd_ptr_reg;
  logic [7:0]        beat_cnt_reg;
  logic [7:0]        head_len;
  logic              gen_last;
  logic              err_wlast_reg;

  assign head_len  = len_mem[len_rd_ptr_reg];
  assign gen_last  = (beat_cnt_reg == head_len);
  assign out_wlast = gen_last;
  assign w_term    = w_hs && gen_last;
  assign err_wlast = err_wlast_reg;

  // awlen of every issued burst, consumed in issue order by the W side
  always_ff @(posedge clk) begin
    if (len_push) begin
      len_mem[len_wr_ptr_reg] <= out_awlen;
    end
  end

  // Length FIFO pointers; explicit wrap keeps MAX_OUTSTANDING=1 working
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_wr_ptr_reg <= '0;
      len_rd_ptr_reg <= '0;
    end else begin
      if (len_push) begin
        len_wr_ptr_reg <= (len_wr_ptr_reg == LEN_PW'(MAX_OUTSTANDING - 1)) ?
                          '0 : len_wr_ptr_reg + LEN_PW'(1);
      end
      if (len_pop) begin
        len_rd_ptr_reg <= (len_rd_ptr_reg == LEN_PW'(MAX_OUTSTANDING - 1)) ?
                          '0 : len_rd_ptr_reg + LEN_PW'(1);
      end
    end
  end

  // Beat counter: counts handshakes within the current burst, cleared on its last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
    end else if (w_hs) begin
      beat_cnt_reg <= gen_last ? 8'd0 : beat_cnt_reg + 8'd1;
    end
  end

  // Sticky flag for an upstream wlast that disagrees with the generated one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_wlast_reg <= 1'b0;
    end else if (w_hs && (in_wlast != gen_last)) begin
      err_wlast_reg <= 1'b1;
    end
  end
`else
  // Bursts are delimited purely by the upstream wlast
  assign out_wlast = in_wlast;
  assign w_term    = w_hs && in_wlast;
  assign err_wlast = 1'b0;
`endif

endmodule

// File: tb/tb_axi_aw_w_joiner.sv
// Self-checking bench for axi_aw_w_joiner: directed scenarios followed by a
// randomized run checked against a queue-based transaction model.
`timescale 1ns/1ps
module tb_axi_aw_w_joiner;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int AWD = 4;
  localparam int MO  = 4;
  localparam int OW  = $clog2(MO) + 1;
`ifdef AXI_JOINER_WLAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [1:0]    burst;
    logic [2:0]    size;
    logic [7:0]    len;
  } aw_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   in_awaddr;
  logic [IW-1:0]   in_awid;
  logic [1:0]      in_awburst;
  logic [2:0]      in_awsize;
  logic [7:0]      in_awlen;
  logic            in_awvalid;
  logic            in_awready;
  logic [DW-1:0]   in_wdata;
  logic [DW/8-1:0] in_wstrb;
  logic            in_wlast;
  logic            in_wvalid;
  logic            in_wready;
  logic [AW-1:0]   out_awaddr;
  logic [IW-1:0]   out_awid;
  logic [1:0]      out_awburst;
  logic [2:0]      out_awsize;
  logic [7:0]      out_awlen;
  logic            out_awvalid;
  logic            out_awready;
  logic [DW-1:0]   out_wdata;
  logic [DW/8-1:0] out_wstrb;
  logic            out_wlast;
  logic            out_wvalid;
  logic            out_wready;
  logic [OW-1:0]   outstanding;
  logic            err_wlast;

  int tests = 0;
  int fails = 0;

  // reference model state
  aw_t        m_aw_q[$];
  logic [7:0] m_len_q[$];
  logic [7:0] m_beats;
  bit         m_err;

  always #5 clk = ~clk;

  axi_aw_w_joiner #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .AW_DEPTH(AWD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_awaddr(in_awaddr), .in_awid(in_awid), .in_awburst(in_awburst),
    .in_awsize(in_awsize), .in_awlen(in_awlen),
    .in_awvalid(in_awvalid), .in_awready(in_awready),
    .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast),
    .in_wvalid(in_wvalid), .in_wready(in_wready),
    .out_awaddr(out_awaddr), .out_awid(out_awid), .out_awburst(out_awburst),
    .out_awsize(out_awsize), .out_awlen(out_awlen),
    .out_awvalid(out_awvalid), .out_awready(out_awready),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wlast(out_wlast),
    .out_wvalid(out_wvalid), .out_wready(out_wready),
    .outstanding(outstanding), .err_wlast(err_wlast)
  );

  task automatic idle_inputs();
    in_awvalid = 1'b0; in_awaddr = '0; in_awid = '0; in_awburst = 2'b01;
    in_awsize = 3'd3; in_awlen = '0;
    in_wvalid = 1'b0; in_wdata = '0; in_wstrb = '0; in_wlast = 1'b0;
    out_awready = 1'b0; out_wready = 1'b0;
  endtask

  task automatic set_aw(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
    in_awaddr = a; in_awid = id; in_awburst = 2'b01; in_awsize = 3'd3; in_awlen = len;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_aw_q.delete();
    m_len_q.delete();
    m_beats = '0;
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (in_awready !== 1'b1) begin fails++; $display("FAIL reset_in_awready: got %b expected 1", in_awready); end
    tests++; if (out_awvalid !== 1'b0) begin fails++; $display("FAIL reset_out_awvalid: got %b expected 0", out_awvalid); end
    tests++; if (out_wvalid !== 1'b0) begin fails++; $display("FAIL reset_out_wvalid: got %b expected 0", out_wvalid); end
    tests++; if (in_wready !== 1'b0) begin fails++; $display("FAIL reset_in_wready: got %b expected 0", in_wready); end
    tests++; if (outstanding !== OW'(0)) begin fails++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    tests++; if (err_wlast !== 1'b0) begin fails++; $display("FAIL reset_err_wlast: got %b expected 0", err_wlast); end
    next_cycle();
  endtask

  task automatic test_single_burst();
    int nb;
    nb = 0;
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_awvalid = (cyc == 0);
      set_aw(32'h1000, 4'h1, 8'd3);
      out_awready = 1'b1; out_wready = 1'b1; in_wvalid = 1'b1;
      in_wdata = 64'hD000 + 64'(nb); in_wstrb = '1; in_wlast = (nb == 3);
      @(negedge clk);
      tests++; if (out_awvalid !== (cyc == 1)) begin fails++; $display("FAIL single_awvalid cyc%0d: got %b expected %b", cyc, out_awvalid, (cyc == 1)); end
      if (cyc == 1) begin
        tests++; if (out_awaddr !== 32'h1000 || out_awlen !== 8'd3) begin fails++; $display("FAIL single_aw_payload: got addr %h len %0d expected addr 1000 len 3", out_awaddr, out_awlen); end
      end
      tests++; if (out_wvalid !== (cyc >= 2 && cyc <= 5)) begin fails++; $display("FAIL single_wvalid cyc%0d: got %b expected %b", cyc, out_wvalid, (cyc >= 2 && cyc <= 5)); end
      tests++; if (outstanding !== ((cyc >= 2 && cyc <= 5) ? OW'(1) : OW'(0))) begin fails++; $display("FAIL single_outstanding cyc%0d: got %0d", cyc, outstanding); end
      if (out_wvalid) begin
        tests++; if (out_wlast !== (nb == 3)) begin fails++; $display("FAIL single_wlast beat%0d: got %b expected %b", nb + 1, out_wlast, (nb == 3)); end
        tests++; if (out_wdata !== 64'hD000 + 64'(nb)) begin fails++; $display("FAIL single_wdata beat%0d: got %h expected %h", nb + 1, out_wdata, 64'hD000 + 64'(nb)); end
        $display("[TB] single burst beat %0d data %h last %b", nb + 1, out_wdata, out_wlast);
        nb++;
      end
      next_cycle();
    end
    tests++; if (nb != 4) begin fails++; $display("FAIL single_beat_count: got %0d expected 4", nb); end
    tests++; if (err_wlast !== 1'b0) begin fails++; $display("FAIL single_err_wlast: got %b expected 0", err_wlast); end
  endtask

  task automatic test_w_before_aw();
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_wvalid = 1'b1; in_wdata = 64'(cyc); in_wstrb = '1; in_wlast = 1'b1;
      out_wready = 1'b1; out_awready = 1'b1;
      in_awvalid = (cyc == 5);
      set_aw(32'h2000, 4'h2, 8'd0);
      @(negedge clk);
      tests++; if (in_wready !== (cyc == 7)) begin fails++; $display("FAIL wfirst_in_wready cyc%0d: got %b expected %b", cyc, in_wready, (cyc == 7)); end
      tests++; if (out_wvalid !== (cyc == 7)) begin fails++; $display("FAIL wfirst_out_wvalid cyc%0d: got %b expected %b", cyc, out_wvalid, (cyc == 7)); end
      if (out_wvalid) $display("[TB] w-before-aw beat released in cycle %0d", cyc);
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int sent;
    int got;
    sent = 0; got = 0;
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_awready = (cyc >= 6);
      in_awvalid = (sent < 5);
      set_aw(32'h3000 + 32'(sent * 16), IW'(sent), 8'd0);
      @(negedge clk);
      if (cyc <= 6) begin
        tests++; if (in_awready !== (cyc < 4)) begin fails++; $display("FAIL bp_in_awready cyc%0d: got %b expected %b", cyc, in_awready, (cyc < 4)); end
      end
      if (in_awvalid && in_awready) sent++;
      if (out_awvalid && out_awready) begin
        tests++; if (out_awaddr !== 32'h3000 + 32'(got * 16)) begin fails++; $display("FAIL bp_order: got %h expected %h", out_awaddr, 32'h3000 + 32'(got * 16)); end
        $display("[TB] backpressure issue %0d addr %h", got, out_awaddr);
        got++;
      end
      next_cycle();
    end
    @(negedge clk);
    tests++; if (got != 4) begin fails++; $display("FAIL bp_issued: got %0d expected 4", got); end
    tests++; if (out_awvalid !== 1'b0) begin fails++; $display("FAIL bp_len_full_awvalid: got %b expected 0", out_awvalid); end
    next_cycle();
  endtask

  task automatic test_outstanding_limit();
    int sent;
    int issued;
    sent = 0; issued = 0;
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_awvalid = (sent < 5);
      set_aw(32'h4000 + 32'(sent * 16), IW'(sent), 8'd0);
      out_awready = 1'b1;
      @(negedge clk);
      if (in_awvalid && in_awready) sent++;
      if (out_awvalid && out_awready) issued++;
      next_cycle();
    end
    @(negedge clk);
    tests++; if (outstanding !== OW'(4)) begin fails++; $display("FAIL lim_outstanding: got %0d expected 4", outstanding); end
    tests++; if (out_awvalid !== 1'b0) begin fails++; $display("FAIL lim_awvalid_5th: got %b expected 0", out_awvalid); end
    tests++; if (issued != 4) begin fails++; $display("FAIL lim_issued: got %0d expected 4", issued); end
    next_cycle();
    in_wvalid = 1'b1; in_wlast = 1'b1; in_wdata = 64'h55; in_wstrb = '1; out_wready = 1'b1;
    @(negedge clk);
    tests++; if (in_wready !== 1'b1) begin fails++; $display("FAIL lim_w_ready: got %b expected 1", in_wready); end
    $display("[TB] outstanding limit: single-beat burst completed");
    next_cycle();
    in_wvalid = 1'b0; in_wlast = 1'b0;
    @(negedge clk);
    tests++; if (outstanding !== OW'(3)) begin fails++; $display("FAIL lim_after_done: got %0d expected 3", outstanding); end
    tests++; if (out_awvalid !== 1'b1 || out_awaddr !== 32'h4040) begin fails++; $display("FAIL lim_release: got valid %b addr %h expected 1 4040", out_awvalid, out_awaddr); end
    next_cycle();
    @(negedge clk);
    tests++; if (outstanding !== OW'(4)) begin fails++; $display("FAIL lim_refill: got %0d expected 4", outstanding); end
    next_cycle();
  endtask

`ifdef AXI_JOINER_WLAST_CHECK_EN
  task automatic test_wlast_check();
    int nb;
    nb = 0;
    do_reset();
    for (int cyc = 0; cyc < 7; cyc++) begin
      in_awvalid = (cyc == 0);
      set_aw(32'h5000, 4'h5, 8'd1);
      out_awready = 1'b1; out_wready = 1'b1; in_wvalid = 1'b1;
      in_wdata = 64'(nb); in_wstrb = '1; in_wlast = (nb == 0);
      @(negedge clk);
      if (out_wvalid) begin
        tests++; if (out_wlast !== (nb == 1)) begin fails++; $display("FAIL chk_wlast beat%0d: got %b expected %b", nb + 1, out_wlast, (nb == 1)); end
        tests++; if (err_wlast !== (nb == 1)) begin fails++; $display("FAIL chk_err beat%0d: got %b expected %b", nb + 1, err_wlast, (nb == 1)); end
        $display("[TB] wlast check beat %0d out_wlast %b err %b", nb + 1, out_wlast, err_wlast);
        nb++;
      end
      next_cycle();
    end
    @(negedge clk);
    tests++; if (nb != 2) begin fails++; $display("FAIL chk_beats: got %0d expected 2", nb); end
    tests++; if (err_wlast !== 1'b1) begin fails++; $display("FAIL chk_err_sticky: got %b expected 1", err_wlast); end
    next_cycle();
  endtask
`else
  task automatic test_wlast_passthrough();
    int nb;
    nb = 0;
    do_reset();
    for (int cyc = 0; cyc < 7; cyc++) begin
      in_awvalid = (cyc == 0);
      set_aw(32'h5000, 4'h5, 8'd1);
      out_awready = 1'b1; out_wready = 1'b1; in_wvalid = 1'b1;
      in_wdata = 64'(nb); in_wstrb = '1; in_wlast = (nb == 0);
      @(negedge clk);
      if (out_wvalid) begin
        tests++; if (out_wlast !== (nb == 0)) begin fails++; $display("FAIL pass_wlast beat%0d: got %b expected %b", nb + 1, out_wlast, (nb == 0)); end
        $display("[TB] wlast passthrough beat %0d out_wlast %b", nb + 1, out_wlast);
        nb++;
      end
      next_cycle();
    end
    @(negedge clk);
    tests++; if (nb != 1) begin fails++; $display("FAIL pass_beats: got %0d expected 1", nb); end
    tests++; if (outstanding !== OW'(0)) begin fails++; $display("FAIL pass_outstanding: got %0d expected 0", outstanding); end
    tests++; if (err_wlast !== 1'b0) begin fails++; $display("FAIL pass_err: got %b expected 0", err_wlast); end
    next_cycle();
  endtask
`endif

  task automatic test_reset_mid_burst();
    int nb;
    nb = 0;
    do_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_awvalid = (cyc == 0);
      set_aw(32'h6000, 4'h6, 8'd3);
      out_awready = 1'b1; out_wready = 1'b1; in_wvalid = 1'b1;
      in_wdata = 64'(nb); in_wstrb = '1; in_wlast = 1'b0;
      @(negedge clk);
      if (out_wvalid) nb++;
      next_cycle();
    end
    tests++; if (nb != 2) begin fails++; $display("FAIL midrst_pre_beats: got %0d expected 2", nb); end
    rst_n = 1'b0;
    #2;
    tests++; if (in_awready !== 1'b1 || out_awvalid !== 1'b0) begin fails++; $display("FAIL midrst_aw: got awready %b awvalid %b expected 1 0", in_awready, out_awvalid); end
    tests++; if (out_wvalid !== 1'b0 || in_wready !== 1'b0) begin fails++; $display("FAIL midrst_w: got wvalid %b wready %b expected 0 0", out_wvalid, in_wready); end
    tests++; if (outstanding !== OW'(0) || err_wlast !== 1'b0) begin fails++; $display("FAIL midrst_state: got outstanding %0d err %b expected 0 0", outstanding, err_wlast); end
    $display("[TB] reset asserted after %0d beats", nb);
    do_reset();
    nb = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      in_awvalid = (cyc == 0);
      set_aw(32'h7000, 4'h7, 8'd1);
      out_awready = 1'b1; out_wready = 1'b1; in_wvalid = 1'b1;
      in_wdata = 64'hA0 + 64'(nb); in_wstrb = '1; in_wlast = (nb == 1);
      @(negedge clk);
      if (out_wvalid) begin
        tests++; if (out_wlast !== (nb == 1) || out_wdata !== 64'hA0 + 64'(nb)) begin fails++; $display("FAIL midrst_new_beat%0d: got last %b data %h", nb + 1, out_wlast, out_wdata); end
        nb++;
      end
      next_cycle();
    end
    @(negedge clk);
    tests++; if (nb != 2 || outstanding !== OW'(0)) begin fails++; $display("FAIL midrst_new_burst: got beats %0d outstanding %0d expected 2 0", nb, outstanding); end
    tests++; if (err_wlast !== 1'b0) begin fails++; $display("FAIL midrst_err: got %b expected 0", err_wlast); end
    next_cycle();
  endtask

  task automatic test_random();
    aw_t  hd;
    aw_t  got_aw;
    bit   e_awrdy, e_awv, e_open, e_wv, e_wrdy, gen, e_last;
    int   n_aw, n_w;
    n_aw = 0; n_w = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_awvalid  = ($urandom_range(0, 99) < 40);
      in_awaddr   = $urandom;
      in_awid     = IW'($urandom);
      in_awburst  = 2'($urandom);
      in_awsize   = 3'($urandom);
      in_awlen    = 8'($urandom_range(0, 3));
      in_wvalid   = ($urandom_range(0, 99) < 70);
      in_wdata    = {$urandom, $urandom};
      in_wstrb    = 8'($urandom);
      out_awready = ($urandom_range(0, 99) < 60);
      out_wready  = ($urandom_range(0, 99) < 70);
      e_open = (m_len_q.size() != 0);
      gen = 1'b0;
      if (e_open) gen = (m_beats == m_len_q[0]);
      in_wlast = ($urandom_range(0, 9) == 0) ? !gen : gen;
      @(negedge clk);
      e_awrdy = (m_aw_q.size() < AWD);
      e_awv   = (m_aw_q.size() != 0) && (m_len_q.size() < MO);
      e_wv    = in_wvalid && e_open;
      e_wrdy  = out_wready && e_open;
      e_last  = CHK ? gen : in_wlast;
      tests++; if (in_awready !== e_awrdy) begin fails++; $display("FAIL rnd_in_awready cyc%0d: got %b expected %b", cyc, in_awready, e_awrdy); end
      tests++; if (out_awvalid !== e_awv) begin fails++; $display("FAIL rnd_out_awvalid cyc%0d: got %b expected %b", cyc, out_awvalid, e_awv); end
      tests++; if (out_wvalid !== e_wv) begin fails++; $display("FAIL rnd_out_wvalid cyc%0d: got %b expected %b", cyc, out_wvalid, e_wv); end
      tests++; if (in_wready !== e_wrdy) begin fails++; $display("FAIL rnd_in_wready cyc%0d: got %b expected %b", cyc, in_wready, e_wrdy); end
      tests++; if (outstanding !== OW'(m_len_q.size())) begin fails++; $display("FAIL rnd_outstanding cyc%0d: got %0d expected %0d", cyc, outstanding, m_len_q.size()); end
      tests++; if (err_wlast !== m_err) begin fails++; $display("FAIL rnd_err_wlast cyc%0d: got %b expected %b", cyc, err_wlast, m_err); end
      if (e_awv) begin
        got_aw = {out_awaddr, out_awid, out_awburst, out_awsize, out_awlen};
        tests++; if (got_aw !== m_aw_q[0]) begin fails++; $display("FAIL rnd_aw_payload cyc%0d: got %h expected %h", cyc, got_aw, m_aw_q[0]); end
      end
      if (e_wv) begin
        tests++; if (out_wlast !== e_last || out_wdata !== in_wdata || out_wstrb !== in_wstrb) begin fails++; $display("FAIL rnd_w_payload cyc%0d: got last %b data %h strb %h expected last %b data %h strb %h", cyc, out_wlast, out_wdata, out_wstrb, e_last, in_wdata, in_wstrb); end
      end
      // advance the model by the handshakes of this cycle
      if (in_wvalid && e_wrdy) begin
        n_w++;
        if (CHK && (in_wlast != gen)) m_err = 1'b1;
        if (e_last) begin
          void'(m_len_q.pop_front());
          m_beats = '0;
        end else begin
          m_beats = m_beats + 8'd1;
        end
      end
      if (e_awv && out_awready) begin
        hd = m_aw_q.pop_front();
        m_len_q.push_back(hd.len);
      end
      if (in_awvalid && e_awrdy) begin
        n_aw++;
        m_aw_q.push_back({in_awaddr, in_awid, in_awburst, in_awsize, in_awlen});
      end
      next_cycle();
    end
    $display("[TB] random run: %0d AWs accepted, %0d W beats forwarded", n_aw, n_w);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_burst();
    test_w_before_aw();
    test_backpressure();
    test_outstanding_limit();
`ifdef AXI_JOINER_WLAST_CHECK_EN
    test_wlast_check();
`else
    test_wlast_passthrough();
`endif
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
